exc_request: RTL and testbench

Exception request controller feeding the pipeline's exception unit. Collects the three exception sources: data-memory misalignment, undefined opcode and external interrupt. Prioritises them, then drives a registered `Exc` request with a stable `EStatus` code until the exception unit returns `ExcAck`. It masks new requests until the handler executes `ERet`, and counts synchronous exceptions dropped while masked.

---
 rtl/exc_request.sv | 151 +++++++++++++++
 tb/tb_exc_request.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_request.sv
// exc_request: exception request controller for the pipeline's exception unit.
// Prioritises misaligned access, undefined opcode and external interrupt. It
// then holds a registered request with a stable cause code until it is
// acknowledged, and masks new requests until the handler returns.
// Ports:
//   clk, reset (async, active-low)
//   ext_irq        async interrupt level, synchronised internally
//   irq_en         interrupt enable (pending IRQ held while low)
//   invalid_op_D   undefined opcode pulse from decode
//   misalign_M     misaligned access pulse from memory stage
//   ExcAck         exception unit has taken the request
//   ERet           handler executes exception return
//   Exc            registered exception request
//   EStatus        cause code, valid while Exc=1
//   in_handler     high while the handler runs
//   irq_pending    latched, not-yet-served interrupt
//   drop_count     saturating count of dropped synchronous exceptions
module exc_request #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_irq,
  input  logic             irq_en,
  input  logic             invalid_op_D,
  input  logic             misalign_M,
  input  logic             ExcAck,
  input  logic             ERet,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic             in_handler,
  output logic             irq_pending,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned CODE_W = 4;
  localparam logic [CODE_W-1:0] CODE_NONE     = CODE_W'(0);
  localparam logic [CODE_W-1:0] CODE_IRQ      = CODE_W'(1);
  localparam logic [CODE_W-1:0] CODE_UNDEF    = CODE_W'(2);
  localparam logic [CODE_W-1:0] CODE_MISALIGN = CODE_W'(3);
  localparam logic [CNT_W-1:0]  CNT_MAX       = '1;

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

  state_t              state, state_nx;
  logic                exc_nx;
  logic [CODE_W-1:0]   estatus_nx;
  logic                in_handler_nx;
  logic                irq_pending_nx;
  logic [CNT_W-1:0]    drop_count_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                irq_prev_q;
  logic                irq_rise;
  logic                sync_cause;
  logic                drop;
  logic                irq_served;

  // Synchroniser chain plus the delayed copy used for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      irq_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      irq_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_rise   = sync_q[SYNC_STAGES-1] & ~irq_prev_q;
  assign sync_cause = misalign_M | invalid_op_D;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      Exc         <= 1'b0;
      EStatus     <= CODE_NONE;
      in_handler  <= 1'b0;
      irq_pending <= 1'b0;
      drop_count  <= '0;
    end else begin
      state       <= state_nx;
      Exc         <= exc_nx;
      EStatus     <= estatus_nx;
      in_handler  <= in_handler_nx;
      irq_pending <= irq_pending_nx;
      drop_count  <= drop_count_nx;
    end
  end

  // Next state, prioritised cause capture and drop detection
  always_comb begin
    state_nx      = state;
    exc_nx        = Exc;
    estatus_nx    = EStatus;
    in_handler_nx = in_handler;
    drop          = 1'b0;
    irq_served    = 1'b0;
    unique case (state)
      IDLE: begin
        exc_nx        = 1'b0;
        estatus_nx    = CODE_NONE;
        in_handler_nx = 1'b0;
        if (misalign_M) begin
          state_nx   = REQ;
          exc_nx     = 1'b1;
          estatus_nx = CODE_MISALIGN;
          drop       = invalid_op_D;  // losing synchronous cause is lost
        end else if (invalid_op_D) begin
          state_nx   = REQ;
          exc_nx     = 1'b1;
          estatus_nx = CODE_UNDEF;
        end else if (irq_pending && irq_en) begin
          state_nx   = REQ;
          exc_nx     = 1'b1;
          estatus_nx = CODE_IRQ;
          irq_served = 1'b1;
        end
      end
      REQ: begin
        drop = sync_cause;
        if (ExcAck) begin
          state_nx      = HANDLER;
          exc_nx        = 1'b0;
          estatus_nx    = CODE_NONE;
          in_handler_nx = 1'b1;
        end
      end
      HANDLER: begin
        drop = sync_cause;
        if (ERet) begin
          state_nx      = IDLE;
          in_handler_nx = 1'b0;
        end
      end
      default: begin
        state_nx      = IDLE;
        exc_nx        = 1'b0;
        estatus_nx    = CODE_NONE;
        in_handler_nx = 1'b0;
      end
    endcase

    // An edge arriving while the IRQ is being captured merges into it
    irq_pending_nx = irq_served ? 1'b0 : (irq_pending | irq_rise);
    drop_count_nx  = (drop && (drop_count != CNT_MAX)) ? drop_count + CNT_W'(1)
                                                       : drop_count;
  end

endmodule

// File: tb/tb_exc_request.sv
// tb_exc_request: directed plus randomized bench for exc_request, checked
// against a cycle-level behavioural model of the controller.
module tb_exc_request;

  localparam int unsigned SS  = 2;
  localparam int unsigned CW  = 2;
  localparam int          SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ext_irq = 1'b0;
  logic          irq_en = 1'b0;
  logic          invalid_op_D = 1'b0;
  logic          misalign_M = 1'b0;
  logic          ExcAck = 1'b0;
  logic          ERet = 1'b0;
  logic          Exc;
  logic [3:0]    EStatus;
  logic          in_handler;
  logic          irq_pending;
  logic [CW-1:0] drop_count;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 = waiting for a cause, 1 = request raised, 2 = in handler
  int   m_phase;
  int   m_code;
  bit   m_pend;
  int   m_drops;
  bit   m_hist[SS+2];  // m_hist[k] = ext_irq as sampled k edges ago

  exc_request #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ext_irq(ext_irq), .irq_en(irq_en),
    .invalid_op_D(invalid_op_D), .misalign_M(misalign_M),
    .ExcAck(ExcAck), .ERet(ERet), .Exc(Exc), .EStatus(EStatus),
    .in_handler(in_handler), .irq_pending(irq_pending),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_code  = 0;
    m_pend  = 1'b0;
    m_drops = 0;
    for (int k = 0; k < SS + 2; k++) m_hist[k] = 1'b0;
  endfunction

  function automatic void count_drop();
    if (m_drops < SAT) m_drops++;
  endfunction

  // One rising clock edge applied to the model using the current inputs
  function automatic void model_edge();
    bit rise;
    bit served;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int k = SS + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ext_irq;
    rise   = m_hist[SS] && !m_hist[SS+1];
    served = 1'b0;
    case (m_phase)
      0: begin
        if (misalign_M) begin
          m_code = 3; m_phase = 1;
          if (invalid_op_D) count_drop();
        end else if (invalid_op_D) begin
          m_code = 2; m_phase = 1;
        end else if (m_pend && irq_en) begin
          m_code = 1; m_phase = 1; served = 1'b1;
        end
      end
      1: begin
        if (misalign_M || invalid_op_D) count_drop();
        if (ExcAck) m_phase = 2;
      end
      default: begin
        if (misalign_M || invalid_op_D) count_drop();
        if (ERet) m_phase = 0;
      end
    endcase
    if (served) m_pend = 1'b0;
    else if (rise) m_pend = 1'b1;
  endfunction

  task automatic check_all();
    chk("Exc",         32'(Exc),         32'(m_phase == 1));
    chk("EStatus",     32'(EStatus),     (m_phase == 1) ? 32'(m_code) : 32'd0);
    chk("in_handler",  32'(in_handler),  32'(m_phase == 2));
    chk("irq_pending", 32'(irq_pending), 32'(m_pend));
    chk("drop_count",  32'(drop_count),  32'(m_drops));
  endtask

  // Advance one edge, then compare everything 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int exp_sat[5];
    exp_sat = '{1, 2, 3, 3, 3};
    model_reset();

    // Reset held for 3 cycles, then released
    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_Exc", 32'(Exc), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);

    // Synchronous cause and handshake
    repeat (2) step();
    misalign_M = 1'b1; step(); misalign_M = 1'b0;
    chk("mis_Exc", 32'(Exc), 32'd1);
    chk("mis_code", 32'(EStatus), 32'd3);
    repeat (2) step();
    chk("mis_hold", 32'(EStatus), 32'd3);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    chk("ack_Exc", 32'(Exc), 32'd0);
    chk("ack_inh", 32'(in_handler), 32'd1);
    repeat (3) step();
    ERet = 1'b1; step(); ERet = 1'b0;
    chk("eret_inh", 32'(in_handler), 32'd0);

    // Pending IRQ masked, then priority with both synchronous causes
    irq_en = 1'b0; ext_irq = 1'b1;
    step(); step();
    chk("pend_early", 32'(irq_pending), 32'd0);
    step();
    chk("pend_set", 32'(irq_pending), 32'd1);
    chk("pend_masked", 32'(Exc), 32'd0);
    step();
    misalign_M = 1'b1; invalid_op_D = 1'b1; step();
    misalign_M = 1'b0; invalid_op_D = 1'b0;
    chk("prio_code", 32'(EStatus), 32'd3);
    chk("prio_drop", 32'(drop_count), 32'd1);
    chk("prio_pend", 32'(irq_pending), 32'd1);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    irq_en = 1'b1;
    ERet = 1'b1; step(); ERet = 1'b0;
    chk("prio_idle_Exc", 32'(Exc), 32'd0);
    step();
    chk("irq_Exc", 32'(Exc), 32'd1);
    chk("irq_code", 32'(EStatus), 32'd1);
    chk("irq_clr", 32'(irq_pending), 32'd0);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    ERet = 1'b1; step(); ERet = 1'b0;
    ext_irq = 1'b0;
    repeat (4) step();

    // IRQ masking then enabling
    irq_en = 1'b0; ext_irq = 1'b1;
    step(); step();
    chk("mask_pend0", 32'(irq_pending), 32'd0);
    step();
    chk("mask_pend1", 32'(irq_pending), 32'd1);
    repeat (7) step();
    chk("mask_Exc", 32'(Exc), 32'd0);
    irq_en = 1'b1; step();
    chk("en_Exc", 32'(Exc), 32'd1);
    chk("en_code", 32'(EStatus), 32'd1);
    chk("en_clr", 32'(irq_pending), 32'd0);
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    ERet = 1'b1; step(); ERet = 1'b0;
    ext_irq = 1'b0;
    repeat (4) step();

    // Saturation of the drop counter in HANDLER
    reset = 1'b0; step(); reset = 1'b1;
    misalign_M = 1'b1; step(); misalign_M = 1'b0;
    ExcAck = 1'b1; step(); ExcAck = 1'b0;
    invalid_op_D = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("sat", 32'(drop_count), 32'(exp_sat[i]));
    end
    invalid_op_D = 1'b0;
    ERet = 1'b1; step(); ERet = 1'b0;

    // ExcAck and ERet together in REQ
    invalid_op_D = 1'b1; step(); invalid_op_D = 1'b0;
    chk("undef_code", 32'(EStatus), 32'd2);
    ExcAck = 1'b1; ERet = 1'b1; step(); ExcAck = 1'b0; ERet = 1'b0;
    chk("both_inh", 32'(in_handler), 32'd1);
    step();
    chk("both_stay", 32'(in_handler), 32'd1);
    ERet = 1'b1; step(); ERet = 1'b0;

    // Asynchronous reset in the middle of REQ
    misalign_M = 1'b1; step(); misalign_M = 1'b0;
    chk("pre_rst_Exc", 32'(Exc), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_Exc", 32'(Exc), 32'd0);
    chk("async_code", 32'(EStatus), 32'd0);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_Exc", 32'(Exc), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      misalign_M   = ($urandom % 8) == 0;
      invalid_op_D = ($urandom % 7) == 0;
      ExcAck       = ($urandom % 4) == 0;
      ERet         = ($urandom % 5) == 0;
      irq_en       = ($urandom % 4) != 0;
      if (($urandom % 6) == 0) ext_irq = ~ext_irq;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
